// File: rtl/aes_pkg.sv
// Shared AES tables and round-transform functions for the iterative cipher cores.
// State byte 0 sits in bits [127:120]; bytes 0-3 form column 0.
package aes_pkg;

   localparam int         NR         = 10;
   localparam logic [7:0] RCON_FIRST = 8'h01;

   typedef logic [127:0] aes_block_t;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} aes_fsm_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Inverse derived from the forward table so both cores share one source.
   function automatic logic [7:0] invSbox(input logic [7:0] b);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 256; i++)
         if (SBOX[8'(i)] == b) r = 8'(i);
      return r;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] getByte(input aes_block_t s, input int idx);
      logic [6:0] lsb;
      lsb = 7'(8 * (15 - idx));
      return s[lsb +: 8];
   endfunction

   function automatic aes_block_t putByte(input aes_block_t s, input int idx, input logic [7:0] v);
      logic [6:0] lsb;
      lsb = 7'(8 * (15 - idx));
      s[lsb +: 8] = v;
      return s;
   endfunction

   function automatic logic [31:0] rotWord(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic aes_block_t subBytes(input aes_block_t s);
      aes_block_t r;
      r = '0;
      for (int i = 0; i < 16; i++) r = putByte(r, i, sbox(getByte(s, i)));
      return r;
   endfunction

   // Row r of column c takes the byte from column (c + r) mod 4.
   function automatic aes_block_t shiftRows(input aes_block_t s);
      aes_block_t r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++)
            r = putByte(r, row + 4 * c, getByte(s, row + 4 * ((c + row) % 4)));
      return r;
   endfunction

   function automatic aes_block_t mixColumns(input aes_block_t s);
      aes_block_t r;
      logic [7:0] a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = getByte(s, 4 * c);
         a1 = getByte(s, 4 * c + 1);
         a2 = getByte(s, 4 * c + 2);
         a3 = getByte(s, 4 * c + 3);
         r = putByte(r, 4 * c,     xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3);
         r = putByte(r, 4 * c + 1, a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3);
         r = putByte(r, 4 * c + 2, a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3);
         r = putByte(r, 4 * c + 3, xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3));
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current one and rcon.
// Purely combinational.
module aes_key_step
   import aes_pkg::*;
(
   input  logic [127:0] key_in,
   input  logic [7:0]   rcon,
   output logic [127:0] key_out
);

   logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = key_in;
   assign t  = subWord(rotWord(w3)) ^ {rcon, 24'h000000};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock, keys expanded on the fly, result held until taken.
// Ciphertext valid 10 cycles after accept; no new block is accepted until the result is consumed.
module aes_enc_iter
   import aes_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_plaintext,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_ciphertext,
   output logic [127:0] out_last_key
);

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   if (NR != 10) begin : gNrCheck
      $error("aes_enc_iter supports only NR = 10 (AES-128)");
   end

   aes_fsm_t   fsmState, fsmNext;
   aes_block_t blockReg, keyReg, nextKey, shifted, roundOut;
   logic [7:0] rconReg;
   logic [3:0] roundCnt;

   aes_key_step uKeyStep (
      .key_in (keyReg),
      .rcon   (rconReg),
      .key_out(nextKey)
   );

   // The final round skips MixColumns.
   always_comb begin
      shifted  = shiftRows(subBytes(blockReg));
      roundOut = (roundCnt == LAST_ROUND) ? (shifted ^ nextKey) : (mixColumns(shifted) ^ nextKey);
   end

   always_comb begin
      fsmNext = fsmState;
      case (fsmState)
         IDLE:    if (in_valid) fsmNext = BUSY;
         BUSY:    if (roundCnt == LAST_ROUND) fsmNext = DONE;
         DONE:    if (out_ready) fsmNext = IDLE;
         default: fsmNext = IDLE;
      endcase
   end

   assign in_ready  = (fsmState == IDLE);
   assign out_valid = (fsmState == DONE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) fsmState <= IDLE;
      else          fsmState <= fsmNext;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         blockReg       <= '0;
         keyReg         <= '0;
         rconReg        <= 8'h00;
         roundCnt       <= 4'd0;
         out_ciphertext <= '0;
         out_last_key   <= '0;
      end else begin
         case (fsmState)
            IDLE: if (in_valid) begin
               blockReg <= in_plaintext ^ in_key;
               keyReg   <= in_key;
               rconReg  <= RCON_FIRST;
               roundCnt <= 4'd1;
            end
            BUSY: begin
               blockReg <= roundOut;
               keyReg   <= nextKey;
               rconReg  <= xtime(rconReg);
               roundCnt <= roundCnt + 4'd1;
               if (roundCnt == LAST_ROUND) begin
                  out_ciphertext <= roundOut;
                  out_last_key   <= nextKey;
                  roundCnt       <= 4'd0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_enc_iter.sv
// Scoreboard bench for aes_enc_iter: a byte-array AES reference predicts each accepted block.
// FIPS vectors, backpressure, mid-block reset, back-to-back and randomized traffic.
module tb_aes_enc_iter;

   typedef struct packed { logic [127:0] ct; logic [127:0] lk; } res_t;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_plaintext = '0;
   logic [127:0] in_key = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] out_ciphertext;
   logic [127:0] out_last_key;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acceptCount = 0;
   bit randReady = 1'b0;

   logic [7:0] sb [256];
   res_t expQ [$];
   int   accQ [$];
   int   riseQ [$];

   bit           knCt = 1'b0, knLk = 1'b0;
   logic [127:0] knCtV = '0, knLkV = '0;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_LK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_LK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   aes_enc_iter #(.NR(10)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_plaintext  (in_plaintext),
      .in_key        (in_key),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_ciphertext(out_ciphertext),
      .out_last_key  (out_last_key)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name, input int lim);
      checks++;
      failures++;
      $display("FAIL timeout %s: event not seen within %0d cycles", name, lim);
   endtask

   // Reference model: GF(2^8) arithmetic, precomputed key schedule, byte arrays.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   task automatic buildSbox();
      logic [7:0] inv;
      for (int v = 0; v < 256; v++) begin
         inv = 8'h00;
         for (int u = 1; u < 256; u++)
            if (gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
         sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic res_t aesRef(input logic [127:0] pt, input logic [127:0] key);
      logic [31:0] w [44];
      logic [7:0]  s [16];
      logic [7:0]  t [16];
      logic [31:0] tmp;
      logic [7:0]  rc, a0, a1, a2, a3;
      res_t r;
      for (int i = 0; i < 4; i++) w[i] = 32'(key >> (32 * (3 - i)));
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++)
         s[i] = 8'(pt >> (8 * (15 - i))) ^ 8'(w[i/4] >> (8 * (3 - i % 4)));
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) s[rr + 4*c] = t[rr + 4*((c + rr) % 4)];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ 8'(w[4*rnd + i/4] >> (8 * (3 - i % 4)));
      end
      r.ct = '0;
      for (int i = 0; i < 16; i++) r.ct = {r.ct[119:0], s[i]};
      r.lk = {w[40], w[41], w[42], w[43]};
      return r;
   endfunction

   // Accept-side predictor and output-side checker, both sampling on the falling edge.
   res_t monExp;
   int   monAcc;
   logic prevOv = 1'b0;
   always @(negedge clock) begin
      if (reset_n) begin
         if (in_valid && in_ready) begin
            monExp = aesRef(in_plaintext, in_key);
            if (knCt) monExp.ct = knCtV;
            if (knLk) monExp.lk = knLkV;
            expQ.push_back(monExp);
            accQ.push_back(cyc + 1);
            acceptCount++;
         end
         if (out_valid && !prevOv) begin
            riseQ.push_back(cyc);
            if (accQ.size() == 0) timeoutFail("out_valid without accepted block", 0);
            else begin
               monAcc = accQ.pop_front();
               chk("latency", 128'(cyc - monAcc), 128'd10);
            end
         end
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) timeoutFail("output without expected entry", 0);
            else begin
               monExp = expQ.pop_front();
               chk("ciphertext", out_ciphertext, monExp.ct);
               chk("last_key", out_last_key, monExp.lk);
            end
         end
         prevOv = out_valid;
      end else begin
         prevOv = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
      if (randReady) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic present(input logic [127:0] pt, input logic [127:0] key,
                          input bit kc, input logic [127:0] ct, input bit kl, input logic [127:0] lk);
      in_plaintext = pt; in_key = key;
      knCt = kc; knCtV = ct; knLk = kl; knLkV = lk;
      in_valid = 1'b1;
   endtask

   task automatic waitAccept(input int lim);
      int start, n;
      start = acceptCount; n = 0;
      while (acceptCount == start && n < lim) begin tick(); n++; end
      if (acceptCount == start) timeoutFail("accept", lim);
   endtask

   task automatic waitIdle(input int lim);
      int n;
      n = 0;
      while (!(expQ.size() == 0 && in_ready === 1'b1) && n < lim) begin tick(); n++; end
      if (!(expQ.size() == 0 && in_ready === 1'b1)) timeoutFail("idle", lim);
   endtask

   task automatic waitOutValid(input int lim);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < lim) begin tick(); n++; end
      if (out_valid !== 1'b1) timeoutFail("out_valid", lim);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [127:0] heldCt, heldLk;
   int accBefore;
   logic [127:0] b2bPt [3];
   logic [127:0] b2bKey [3];
   logic [127:0] b2bCt [3];

   initial begin
      buildSbox();
      tick(); tick();
      chk("reset in_ready", 128'(in_ready), 128'd1);
      chk("reset out_valid", 128'(out_valid), 128'd0);
      chk("reset ciphertext", out_ciphertext, '0);
      chk("reset last_key", out_last_key, '0);
      reset_n = 1'b1;
      tick();

      // Known-answer vectors
      present(C1_PT, C1_KEY, 1, C1_CT, 1, C1_LK); waitAccept(50); in_valid = 1'b0; waitIdle(40);
      present(B_PT, B_KEY, 1, B_CT, 1, B_LK);     waitAccept(50); in_valid = 1'b0; waitIdle(40);
      present('0, '0, 1, Z_CT, 0, '0);            waitAccept(50); in_valid = 1'b0; waitIdle(40);

      // Backpressure: result held, second request ignored until the transfer
      out_ready = 1'b0;
      present(C1_PT, C1_KEY, 1, C1_CT, 1, C1_LK); waitAccept(50); in_valid = 1'b0;
      waitOutValid(20);
      heldCt = out_ciphertext; heldLk = out_last_key;
      present(B_PT, B_KEY, 1, B_CT, 1, B_LK);
      accBefore = acceptCount;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("held ciphertext", out_ciphertext, heldCt);
         chk("held last_key", out_last_key, heldLk);
         chk("held in_ready", 128'(in_ready), 128'd0);
         chk("held out_valid", 128'(out_valid), 128'd1);
      end
      chk("no accept while held", 128'(acceptCount - accBefore), 128'd0);
      out_ready = 1'b1;
      tick();
      chk("release out_valid", 128'(out_valid), 128'd0);
      chk("release in_ready", 128'(in_ready), 128'd1);
      waitAccept(10); in_valid = 1'b0; waitIdle(40);

      // Reset at round 5
      present(C1_PT, C1_KEY, 1, C1_CT, 1, C1_LK); waitAccept(50); in_valid = 1'b0;
      repeat (4) tick();
      reset_n = 1'b0;
      #1;
      chk("midreset out_valid", 128'(out_valid), 128'd0);
      chk("midreset in_ready", 128'(in_ready), 128'd1);
      chk("midreset ciphertext", out_ciphertext, '0);
      chk("midreset last_key", out_last_key, '0);
      expQ.delete(); accQ.delete();
      tick();
      reset_n = 1'b1;
      tick();
      present(C1_PT, C1_KEY, 1, C1_CT, 1, C1_LK); waitAccept(50); in_valid = 1'b0; waitIdle(40);

      // Back-to-back with in_valid held and inputs scrambled while busy
      b2bPt[0] = C1_PT; b2bKey[0] = C1_KEY; b2bCt[0] = C1_CT;
      b2bPt[1] = B_PT;  b2bKey[1] = B_KEY;  b2bCt[1] = B_CT;
      b2bPt[2] = '0;    b2bKey[2] = '0;     b2bCt[2] = Z_CT;
      riseQ.delete();
      for (int b = 0; b < 3; b++) begin
         present(b2bPt[b], b2bKey[b], 1, b2bCt[b], 0, '0);
         waitAccept(50);
         for (int g = 0; g < 5; g++) begin
            in_plaintext = {$urandom, $urandom, $urandom, $urandom};
            in_key       = {$urandom, $urandom, $urandom, $urandom};
            tick();
         end
      end
      in_valid = 1'b0;
      waitIdle(40);
      chk("b2b result count", 128'(riseQ.size()), 128'd3);
      if (riseQ.size() == 3) begin
         chk("b2b spacing 1", 128'(riseQ[1] - riseQ[0]), 128'd12);
         chk("b2b spacing 2", 128'(riseQ[2] - riseQ[1]), 128'd12);
      end

      // Randomized traffic with random consumer stalls
      randReady = 1'b1;
      for (int n = 0; n < 12; n++) begin
         repeat ($urandom_range(0, 3)) tick();
         present({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, '0, 0, '0);
         waitAccept(200);
         in_valid = 1'b0;
      end
      randReady = 1'b0;
      out_ready = 1'b1;
      waitIdle(100);
      chk("scoreboard drained", 128'(expQ.size()), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
